// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - program-loader write port into ifu_fetch_ctrl
//
// Purpose: bundles the loader's valid/ready write handshake so the
// fetch controller and whatever drives program images share one port type.
//
// Signals:
//   ld_valid  loader requests a RAM write this cycle
//   ld_addr   RAM word address of the write (ADDR_W bits)
//   ld_data   32-bit write data
//   ld_ready  controller accepts loader writes this cycle
//
// Modports:
//   master  the loader (drives valid/addr/data, observes ready)
//   slave   the fetch controller (observes valid/addr/data, drives ready)

interface ifu_fetch_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ready;

  modport master (
    output ld_valid,
    output ld_addr,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - fetch sequencer and prog_ram port owner for the IFU
//
// Purpose: steps the IFU through prog_ram one word at a time, allowing for
// the RAM's one-cycle registered read, and hands the single RAM port to the
// program loader whenever no run is in progress (IDLE/HALT).
//
// Per-instruction sequence: ADDR (RAM latches pc) -> WAIT (q valid, IFU
// captures it) -> ISSUE (instruction presented, PC advances on exit).
//
// Parameters:
//   ADDR_W     RAM word-address width (PC bits [ADDR_W+1:2])
//   HALT_WORD  word address after whose issue the run stops by itself
//   CNT_W      width of the issued-instruction counter
//
// Ports:
//   clk1         system clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a run from PC=0 (sampled in IDLE/HALT)
//   halt_req     stop at the next instruction boundary
//   stall        hold the current instruction in ISSUE
//   ld           loader write port (slave side)
//   pc_in        IFU PC_out
//   mem_address  prog_ram.address
//   mem_data     prog_ram.data
//   mem_wren     prog_ram.wren
//   pc_rst       IFU pc_rst
//   sel_pc       IFU sel_pc (1 = PC+4 at next edge)
//   inst_valid   IFU Inst_out holds a freshly fetched instruction
//   busy         a run is in progress
//   issue_cnt    instructions issued in the current run

module ifu_fetch_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] HALT_WORD = 10'h3FF,
  parameter int                CNT_W     = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  ifu_fetch_ctrl_if.slave   ld,
  input  logic [31:0]       pc_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  output logic              pc_rst,
  output logic              sel_pc,
  output logic              inst_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ADDR,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t state;

  // Registered state decodes, updated together with the state so every
  // control output comes straight from a flop.
  logic clr_q;
  logic issue_q;
  logic busy_q;
  logic ldr_q;

  logic [ADDR_W-1:0] pc_word;
  logic              unused_pc_bits;

  assign pc_word        = pc_in[ADDR_W+1:2];
  assign unused_pc_bits = ^{pc_in[31:ADDR_W+2], pc_in[1:0]};

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      clr_q     <= 1'b0;
      issue_q   <= 1'b0;
      busy_q    <= 1'b0;
      ldr_q     <= 1'b1;
      issue_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          // A loader write in this same cycle still lands: ldr_q is
          // only dropped from the next cycle on.
          if (start) begin
            state  <= S_CLR;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
            ldr_q  <= 1'b0;
          end
        end
        S_CLR: begin
          state     <= S_ADDR;
          clr_q     <= 1'b0;
          issue_cnt <= '0;
        end
        S_ADDR: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          state   <= S_ISSUE;
          issue_q <= 1'b1;
        end
        S_ISSUE: begin
          if (!stall) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            issue_q   <= 1'b0;
            // halt_req only matters here, so a fetch already under way
            // always completes; it also outranks a concurrent start.
            if (halt_req || (pc_word == HALT_WORD)) begin
              state  <= S_HALT;
              busy_q <= 1'b0;
              ldr_q  <= 1'b1;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          clr_q   <= 1'b0;
          issue_q <= 1'b0;
          busy_q  <= 1'b0;
          ldr_q   <= 1'b1;
        end
      endcase
    end
  end

  // rst is ORed in so the IFU PC clears on the first edge under reset,
  // independent of the state flops.
  assign pc_rst      = rst | clr_q;
  assign sel_pc      = issue_q & ~stall;
  assign inst_valid  = issue_q;
  assign busy        = busy_q;
  assign ld.ld_ready = ldr_q;

  // RAM port: loader owns it in IDLE/HALT, the fetch path otherwise.
  assign mem_wren    = ldr_q & ld.ld_valid;
  assign mem_address = ldr_q ? ld.ld_addr : pc_word;
  assign mem_data    = ldr_q ? ld.ld_data : 32'd0;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst, start, start2, halt_req, stall;

  ifu_fetch_ctrl_if #(.ADDR_W(10)) ldif ();
  ifu_fetch_ctrl_if #(.ADDR_W(10)) ldif2 ();
  assign ldif2.ld_valid = ldif.ld_valid;
  assign ldif2.ld_addr  = ldif.ld_addr;
  assign ldif2.ld_data  = ldif.ld_data;

  logic [9:0]  addr1, addr2;
  logic [31:0] data1, data2;
  logic        wren1, wren2, prst1, prst2, sel1, sel2, iv1, iv2, busy1, busy2;
  logic [15:0] cnt1, cnt2;
  logic [31:0] pc1, pc2, q1, q2, inst1, inst2;

  ifu_fetch_ctrl dut (
    .clk1(clk1), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .ld(ldif), .pc_in(pc1), .mem_address(addr1), .mem_data(data1), .mem_wren(wren1),
    .pc_rst(prst1), .sel_pc(sel1), .inst_valid(iv1), .busy(busy1), .issue_cnt(cnt1)
  );

  ifu_fetch_ctrl #(.HALT_WORD(10'd2)) dut2 (
    .clk1(clk1), .rst(rst), .start(start2), .halt_req(1'b0), .stall(1'b0),
    .ld(ldif2), .pc_in(pc2), .mem_address(addr2), .mem_data(data2), .mem_wren(wren2),
    .pc_rst(prst2), .sel_pc(sel2), .inst_valid(iv2), .busy(busy2), .issue_cnt(cnt2)
  );

  // Environment: registered-read prog_ram plus IFU (PC register, Inst_out latch).
  logic [31:0] ram1 [0:1023];
  logic [31:0] ram2 [0:1023];
  always @(posedge clk1) begin
    if (wren1) ram1[addr1] <= data1;
    q1 <= ram1[addr1];
    if (prst1) pc1 <= 32'd0; else if (sel1) pc1 <= pc1 + 32'd4;
    inst1 <= q1;
  end
  always @(posedge clk1) begin
    if (wren2) ram2[addr2] <= data2;
    q2 <= ram2[addr2];
    if (prst2) pc2 <= 32'd0; else if (sel2) pc2 <= pc2 + 32'd4;
    inst2 <= q2;
  end

  int n_sel2 = 0;
  always @(posedge clk1) if (sel2) n_sel2 <= n_sel2 + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a run issues word k at PC 4k; the first issue comes
  // 3 idle cycles after the start cycle, each later one 2 cycles after
  // the previous issue; the run ends on the issue that sees halt_req.
  bit          running = 1'b0;
  int          gap = 0;
  int          k = 0;
  logic [31:0] ram_model [0:1023];

  task automatic cyc_begin(input bit st, input bit stl, input bit hr, input bit ldv,
                           input logic [9:0] la, input logic [31:0] ld);
    bit exp_iv;
    @(negedge clk1);
    start = st; stall = stl; halt_req = hr;
    ldif.ld_valid = ldv; ldif.ld_addr = la; ldif.ld_data = ld;
    #1;
    exp_iv = running && (gap == 0);
    chk1("busy", busy1, running);
    chk1("ld_ready", ldif.ld_ready, !running);
    chk1("inst_valid", iv1, exp_iv);
    chk1("sel_pc", sel1, exp_iv && !stl);
    chk1("mem_wren", wren1, !running && ldv);
    chk1("pc_rst", prst1, running && (gap == 3));
    if (exp_iv && !stl) begin
      chk32("pc_at_issue", pc1, 32'(4 * k));
      chk32("inst_at_issue", inst1, ram_model[k]);
      chk32("cnt_at_issue", {16'd0, cnt1}, 32'(k));
    end
    if (!running) chk32("cnt_idle", {16'd0, cnt1}, 32'(k));
    if (!running) begin
      if (ldv) ram_model[la] = ld;
      if (st) begin running = 1'b1; gap = 3; k = 0; end
    end else if (gap > 0) begin
      gap--;
    end else if (!stl) begin
      k++;
      if (hr || (k - 1 == 1023)) running = 1'b0; else gap = 2;
    end
  endtask

  task automatic step(input bit st, input bit stl, input bit hr, input bit ldv,
                      input logic [9:0] la, input logic [31:0] ld);
    cyc_begin(st, stl, hr, ldv, la, ld);
    @(posedge clk1);
  endtask

  typedef struct {
    bit st, stl, hr, ldv;
    logic [9:0] la;
    logic [31:0] ld;
    bit e_iv, e_sel, e_busy, e_ldr, e_wren, e_prst;
    logic [31:0] e_pc;
    bit chk_inst;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t v(input bit st, stl, hr, ldv, input int la, input int ld,
                             input bit iv, sel, bz, ldr, wr, pr,
                             input int pc, input bit ci, input int inst);
    vec_t r;
    r.st = st; r.stl = stl; r.hr = hr; r.ldv = ldv;
    r.la = 10'(la); r.ld = 32'(ld);
    r.e_iv = iv; r.e_sel = sel; r.e_busy = bz; r.e_ldr = ldr; r.e_wren = wr; r.e_prst = pr;
    r.e_pc = 32'(pc); r.chk_inst = ci; r.e_inst = 32'(inst);
    return r;
  endfunction

  vec_t vt[$];

  initial begin
    start = 0; start2 = 0; stall = 0; halt_req = 0;
    ldif.ld_valid = 0; ldif.ld_addr = '0; ldif.ld_data = '0;
    for (int i = 0; i < 1024; i++) ram_model[i] = 32'd0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    chk1("rst_pc_rst", prst1, 1'b1);
    chk1("rst_sel_pc", sel1, 1'b0);
    chk1("rst_inst_valid", iv1, 1'b0);
    chk1("rst_busy", busy1, 1'b0);
    chk1("rst_ld_ready", ldif.ld_ready, 1'b1);
    chk1("rst_mem_wren", wren1, 1'b0);
    chk32("rst_issue_cnt", {16'd0, cnt1}, 32'd0);
    chk32("rst_pc", pc1, 32'd0);
    @(negedge clk1);
    rst = 1'b0;

    // Directed run: load, start, stall, halt_req, blocked/accepted writes
    vt.push_back(v(0,0,0,1,0,102, 0,0,0,1,1,0, 0,0,0));
    vt.push_back(v(0,0,0,1,1,64,  0,0,0,1,1,0, 0,0,0));
    vt.push_back(v(0,0,0,1,2,3,   0,0,0,1,1,0, 0,0,0));
    vt.push_back(v(1,0,0,0,0,0,   0,0,0,1,0,0, 0,0,0));
    vt.push_back(v(0,0,0,1,0,999, 0,0,1,0,0,1, 0,0,0));
    vt.push_back(v(0,0,0,1,1,777, 0,0,1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,0,1,2,555, 0,0,1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,0,1,0,999, 1,1,1,0,0,0, 0,1,102));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 4,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 4,0,0));
    for (int i = 0; i < 5; i++) vt.push_back(v(0,1,0,0,0,0, 1,0,1,0,0,0, 4,1,64));
    vt.push_back(v(0,0,0,0,0,0,   1,1,1,0,0,0, 4,1,64));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 8,0,0));
    vt.push_back(v(0,0,1,0,0,0,   0,0,1,0,0,0, 8,0,0));
    vt.push_back(v(0,0,1,0,0,0,   1,1,1,0,0,0, 8,1,3));
    vt.push_back(v(0,0,0,0,0,0,   0,0,0,1,0,0, 12,0,0));
    vt.push_back(v(1,0,0,0,0,0,   0,0,0,1,0,0, 12,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,1, 12,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0,0,0,   1,1,1,0,0,0, 0,1,102));
    vt.push_back(v(0,0,0,1,0,555, 0,0,0,1,1,0, 4,0,0));
    vt.push_back(v(1,0,0,0,0,0,   0,0,0,1,0,0, 4,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,1, 4,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,0,0,0,0,   0,0,1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0,0,0,   1,1,1,0,0,0, 0,1,555));
    vt.push_back(v(0,0,0,0,0,0,   0,0,0,1,0,0, 4,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      cyc_begin(vt[i].st, vt[i].stl, vt[i].hr, vt[i].ldv, vt[i].la, vt[i].ld);
      chk1($sformatf("row%0d_iv", i), iv1, vt[i].e_iv);
      chk1($sformatf("row%0d_sel", i), sel1, vt[i].e_sel);
      chk1($sformatf("row%0d_busy", i), busy1, vt[i].e_busy);
      chk1($sformatf("row%0d_ldr", i), ldif.ld_ready, vt[i].e_ldr);
      chk1($sformatf("row%0d_wren", i), wren1, vt[i].e_wren);
      chk1($sformatf("row%0d_pcrst", i), prst1, vt[i].e_prst);
      chk32($sformatf("row%0d_pc", i), pc1, vt[i].e_pc);
      if (vt[i].chk_inst) chk32($sformatf("row%0d_inst", i), inst1, vt[i].e_inst);
      @(posedge clk1);
    end
    chk32("cnt_after_runs", {16'd0, cnt1}, 32'd1);

    // HALT_WORD=2 instance: exactly words 0..2 issue, then HALT
    cyc_begin(0,0,0,0,0,0);
    start2 = 1'b1;
    @(posedge clk1);
    cyc_begin(0,0,0,0,0,0);
    start2 = 1'b0;
    @(posedge clk1);
    repeat (18) step(0,0,0,0,0,0);
    cyc_begin(0,0,0,0,0,0);
    chk32("hw2_issues", 32'(n_sel2), 32'd3);
    chk32("hw2_cnt", {16'd0, cnt2}, 32'd3);
    chk32("hw2_pc", pc2, 32'd12);
    chk1("hw2_busy", busy2, 1'b0);
    chk1("hw2_ld_ready", ldif2.ld_ready, 1'b1);
    @(posedge clk1);

    // Randomized runs against the model
    for (int i = 0; i < 32; i++) step(0,0,0,1,10'(i),$urandom);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3) == 0, $urandom_range(2) == 0,
           ($urandom_range(15) == 0) || (k >= 28),
           $urandom_range(1) == 1, 10'($urandom_range(31)), $urandom);
    end
    for (int i = 0; i < 200 && running; i++) step(0,0,1,0,0,0);
    if (running) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: run still active after 200 cycles");
    end

    // start and halt_req together in ISSUE: halt wins, start taken from HALT
    step(1,0,0,0,0,0);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);
    step(1,0,1,0,0,0);
    cyc_begin(1,0,0,0,0,0);
    chk1("halt_wins_busy", busy1, 1'b0);
    chk1("halt_wins_ldr", ldif.ld_ready, 1'b1);
    @(posedge clk1);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);

    // Asynchronous reset in WAIT
    cyc_begin(0,0,0,0,0,0);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_busy", busy1, 1'b0);
    chk1("arst_iv", iv1, 1'b0);
    chk1("arst_sel", sel1, 1'b0);
    chk1("arst_ldr", ldif.ld_ready, 1'b1);
    chk1("arst_pc_rst", prst1, 1'b1);
    chk1("arst_wren", wren1, 1'b0);
    chk32("arst_cnt", {16'd0, cnt1}, 32'd0);
    @(posedge clk1);
    #1;
    chk32("arst_pc", pc1, 32'd0);
    @(negedge clk1);
    rst = 1'b0;
    running = 1'b0; gap = 0; k = 0;
    step(1,0,0,0,0,0);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);
    cyc_begin(0,0,1,0,0,0);
    chk32("ram_kept_after_rst", inst1, ram_model[0]);
    @(posedge clk1);
    step(0,0,0,0,0,0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
